reg_file_2r1w: RTL
==================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter ADDR_W, default 5, address width; register count NREGS = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs1_addr  input  ADDR_W  read port 1 address.
REQ-006 rs2_addr  input  ADDR_W  read port 2 address.
REQ-007 rs1_data  output  XLEN  read port 1 data, combinational.
REQ-008 rs2_data  output  XLEN  read port 2 data, combinational.
REQ-009 write_enable  input  1  write request, sampled at rising clk.
REQ-010 rd_addr  input  ADDR_W  write address.
REQ-011 rd_data  input  XLEN  write data.
REQ-012 ready  output  1  1 = array initialised, writes accepted, reads valid.
REQ-013 wr_dropped  output  1  one-cycle pulse: a write request was discarded because ready=0.

Function
REQ-014 The block SHALL hold NREGS registers of XLEN bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-015 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 CLEAR: a clear pointer starting at 1 SHALL write 0 to registers[pointer] each cycle and increment by 1.
REQ-017 CLEAR -> RUN SHALL occur on the edge that clears register NREGS-1; ready SHALL be 1 from that edge onward, i.e. NREGS-1 edges after rst_n deasserts (31 for defaults).
REQ-018 RUN SHALL be terminal; only rst_n returns the FSM to CLEAR.
REQ-019 While ready=0, rs1_data and rs2_data SHALL be 0 regardless of address.
REQ-020 While ready=0, a sampled write_enable=1 SHALL be ignored and wr_dropped SHALL be 1 in the following cycle; otherwise wr_dropped SHALL be 0.
REQ-021 RUN: when write_enable=1 and rd_addr!=0, registers[rd_addr] SHALL take rd_data at the rising edge; rd_addr=0 SHALL be a silent no-op (no wr_dropped).
REQ-022 RUN: rsN_data SHALL equal 0 when rsN_addr=0, else registers[rsN_addr], with zero-cycle latency.
REQ-023 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-024 Clear pointer SHALL not wrap; it SHALL hold its value in RUN.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force state CLEAR, clear pointer 1, ready 0, wr_dropped 0.
REQ-026 Register contents SHALL NOT be asynchronously reset; the CLEAR sweep SHALL initialise them.
REQ-027 Reset asserted mid-CLEAR or in RUN SHALL restart the sweep from register 1 after release.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 Defined: in RUN, if write_enable=1, rd_addr!=0 and rd_addr==rsN_addr, rsN_data SHALL equal rd_data in the same cycle.
REQ-030 Undefined: rsN_data SHALL show the old register value until the edge after the write.
REQ-031 Forwarding SHALL never apply to address 0 nor while ready=0.

Verification
REQ-032 Release rst_n, count edges -> ready=1 after exactly 31 edges; rs1_addr=7 reads 0x00000000 in RUN.
REQ-033 Write 0xDEADBEEF to x5, next cycle rs1_addr=rs2_addr=5 -> both read 0xDEADBEEF; write 0x12345678 to x0 -> rs1_addr=0 reads 0, wr_dropped=0.
REQ-034 write_enable=1 at edge 10 after release -> wr_dropped=1 next cycle, target register reads 0 once ready=1.
REQ-035 Same cycle write x9=0xA5A5A5A5 with rs2_addr=9 -> with REGFILE_BYPASS_EN rs2_data=0xA5A5A5A5 that cycle; without, old value then 0xA5A5A5A5 after edge.
REQ-036 Fill x1..x31 with index values, assert rst_n mid-cycle -> ready drops immediately, reads 0; after release and 31 edges all registers read 0.
REQ-037 Assert rst_n at edge 15 of CLEAR -> ready stays 0 and becomes 1 exactly 31 edges after the second release.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w -- XLEN x 2**ADDR_W register file, two combinational read
// ports and one synchronous write port. Register 0 is hard-wired to zero.
// After reset a CLEAR sweep zeroes registers 1..NREGS-1 (one per cycle);
// until it finishes, reads return 0 and writes are discarded and flagged
// on wr_dropped.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to a read port addressing the register being written.

module reg_file_2r1w #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    output logic              ready,
    output logic              wr_dropped
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_REG = '1;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [ADDR_W-1:0] FIRST_CLR = ADDR_W'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    // Entry 0 exists only to keep indexing simple; it is never written and
    // never reaches a read port.
    logic [XLEN-1:0] regs [NREGS];

    assign ready = (state_q == RUN);

    // FSM and clear-pointer state register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= FIRST_CLR;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic: sweep up to the last register, then stay in RUN.
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == LAST_REG) begin
                    state_d = RUN;          // pointer holds, never wraps
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Flag a write request that arrived before the array was initialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= write_enable && (state_q != RUN);
        end
    end

    // Storage array: the CLEAR sweep owns the write port until RUN.
    // NOTE: the array has no reset on purpose; the sweep initialises it,
    // which keeps it mappable to plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            regs[clr_ptr_q] <= '0;
        end else if (write_enable && (rd_addr != ZERO_REG)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // Read port 1: zero while not ready or for x0, optional forwarding.
    always_comb begin
        rs1_data = '0;
        if (ready && (rs1_addr != ZERO_REG)) begin
            rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (write_enable && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end
`endif
        end
    end

    // Read port 2: identical structure to port 1, fully independent.
    always_comb begin
        rs2_data = '0;
        if (ready && (rs2_addr != ZERO_REG)) begin
            rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (write_enable && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end
`endif
        end
    end

endmodule
